wavelet_stream_driver: RTL and testbench



---
 rtl/wavelet_stream_driver.sv | 154 +++++++++++++++
 tb/tb_wavelet_stream_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wavelet_stream_driver.sv
// wavelet_stream_driver: host-side driver for the wavelet transform core.
// Presents each accepted sample on o_value with a held o_data_clk strobe, waits
// for the FIR pipeline to settle, sweeps o_select_output_channel over the filter
// channels, captures i_multiplexed_wavelet_out and emits the coefficients as a
// valid/ready stream (one frame per sample).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_sample/i_sample_valid/o_sample_ready   sample input handshake
//   o_value, o_data_clk             sample and data strobe to the core
//   o_select_output_channel         channel select to the core (upper bits 0)
//   i_multiplexed_wavelet_out       muxed coefficient from the core
//   o_coef/o_coef_channel/o_coef_last/o_coef_valid/i_coef_ready  coefficient stream
//   o_busy                          frame in progress
// Optional feature: define WAVELET_DRIVER_MASK_EN to add i_channel_mask, a
// per-frame channel enable sampled at sample accept.
module wavelet_stream_driver #(
    parameter int BITS_PER_ELEM  = 8,
    parameter int SUM_TRUNCATION = 8,
    parameter int NUM_FILTERS    = 7,
    parameter int DATA_CLK_HIGH  = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int MUX_LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BITS_PER_ELEM-1:0]  i_sample,
    input  logic                      i_sample_valid,
    output logic                      o_sample_ready,
    output logic [BITS_PER_ELEM-1:0]  o_value,
    output logic                      o_data_clk,
    output logic [7:0]                o_select_output_channel,
    input  logic [SUM_TRUNCATION-1:0] i_multiplexed_wavelet_out,
    output logic [SUM_TRUNCATION-1:0] o_coef,
    output logic [2:0]                o_coef_channel,
    output logic                      o_coef_last,
    output logic                      o_coef_valid,
    input  logic                      i_coef_ready,
    output logic                      o_busy
`ifdef WAVELET_DRIVER_MASK_EN
    ,
    input  logic [NUM_FILTERS-1:0]    i_channel_mask
`endif
);
    typedef enum logic [2:0] {IDLE, STROBE, SETTLE, WAIT_MUX, EMIT} state_t;

    localparam logic [15:0] STROBE_END = 16'(DATA_CLK_HIGH - 1);
    localparam logic [15:0] SETTLE_END = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] MUX_END    = 16'(MUX_LATENCY - 1);

    state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0] sel_q, first_ch, next_ch;
    logic has_next, accept, handshake, capture, strobe_done;
    // mask_in is the mask seen at accept, mask_q the one governing the frame
    logic [NUM_FILTERS-1:0] mask_in, mask_q;

`ifdef WAVELET_DRIVER_MASK_EN
    assign mask_in = i_channel_mask;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask_q <= '0;
        else if (accept) mask_q <= i_channel_mask;
    end
`else
    assign mask_in = '1;
    assign mask_q  = '1;
`endif

    assign o_sample_ready          = rst_n && state_q == IDLE;
    assign o_busy                  = state_q != IDLE;
    assign o_select_output_channel = {5'd0, sel_q};
    assign accept                  = i_sample_valid && o_sample_ready;
    assign handshake               = o_coef_valid && i_coef_ready;
    assign strobe_done             = state_q == STROBE && cnt_q == STROBE_END;

    // Lowest enabled channel for a new frame, and the next enabled channel
    // above the current select; no next channel means the current one is last.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
            if (mask_in[i]) first_ch = 3'(i);
            if (mask_q[i] && i > int'(sel_q)) begin
                next_ch  = 3'(i);
                has_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) state_d = STROBE;
            end
            STROBE: if (cnt_q == STROBE_END) begin
                cnt_d   = '0;
                state_d = SETTLE_CYCLES != 0 ? SETTLE : (|mask_q ? WAIT_MUX : IDLE);
            end
            SETTLE: if (cnt_q == SETTLE_END) begin
                cnt_d   = '0;
                state_d = |mask_q ? WAIT_MUX : IDLE;
            end
            WAIT_MUX: if (cnt_q == MUX_END) begin
                cnt_d   = '0;
                capture = 1'b1;
                state_d = EMIT;
            end
            EMIT: begin
                cnt_d = '0;
                if (handshake) state_d = o_coef_last ? IDLE : WAIT_MUX;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            sel_q          <= '0;
            o_value        <= '0;
            o_data_clk     <= 1'b0;
            o_coef         <= '0;
            o_coef_channel <= '0;
            o_coef_last    <= 1'b0;
            o_coef_valid   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                o_value    <= i_sample;
                o_data_clk <= 1'b1;
                sel_q      <= first_ch;
            end
            if (strobe_done) o_data_clk <= 1'b0;
            if (capture) begin
                o_coef         <= i_multiplexed_wavelet_out;
                o_coef_channel <= sel_q;
                o_coef_last    <= !has_next;
                o_coef_valid   <= 1'b1;
            end
            // select advances on the handshake edge so the capture lands
            // exactly MUX_LATENCY edges after the select change
            if (state_q == EMIT && handshake) begin
                o_coef_valid <= 1'b0;
                if (!o_coef_last) sel_q <= next_ch;
            end
        end
    end
endmodule

// File: tb/tb_wavelet_stream_driver.sv
// tb_wavelet_stream_driver: scoreboard bench for wavelet_stream_driver.
module tb_wavelet_stream_driver;
    localparam int NF = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] i_sample = '0;
    logic       i_sample_valid = 1'b0;
    logic       o_sample_ready;
    logic [7:0] o_value;
    logic       o_data_clk;
    logic [7:0] o_select_output_channel;
    logic [7:0] mux_q = '0;
    logic [7:0] o_coef;
    logic [2:0] o_coef_channel;
    logic       o_coef_last;
    logic       o_coef_valid;
    logic       i_coef_ready = 1'b1;
    logic       o_busy;
    logic [NF-1:0] mask_drv = '1;

    int n_cmp = 0, n_bad = 0, beats = 0;
    logic [11:0] sb_q[$];
    logic [11:0] held = '0;
    logic        hold_chk = 1'b0;

    wavelet_stream_driver dut (
        .clk(clk), .rst_n(rst_n),
        .i_sample(i_sample), .i_sample_valid(i_sample_valid), .o_sample_ready(o_sample_ready),
        .o_value(o_value), .o_data_clk(o_data_clk),
        .o_select_output_channel(o_select_output_channel),
        .i_multiplexed_wavelet_out(mux_q),
        .o_coef(o_coef), .o_coef_channel(o_coef_channel), .o_coef_last(o_coef_last),
        .o_coef_valid(o_coef_valid), .i_coef_ready(i_coef_ready), .o_busy(o_busy)
`ifdef WAVELET_DRIVER_MASK_EN
        , .i_channel_mask(mask_drv)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // core model: registered output mux, coefficient = 0x10 + channel + (sample - 0x40)
    always @(posedge clk) mux_q <= 8'h10 + o_select_output_channel + o_value - 8'h40;

    // push the expected frame when a sample is accepted
    always @(posedge clk) begin
        if (rst_n && i_sample_valid && o_sample_ready) begin
            int hi;
            hi = -1;
            for (int i = 0; i < NF; i++) if (mask_drv[i]) hi = i;
            for (int c = 0; c < NF; c++)
                if (mask_drv[c]) sb_q.push_back({c == hi, 3'(c), 8'(8'h10 + c + i_sample - 8'h40)});
        end
    end

    // pop on each handshake; a beat held under backpressure must stay stable
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_chk) check("beat_stable", {o_coef_valid, o_coef_last, o_coef_channel, o_coef}, {1'b1, held});
            hold_chk = 1'b0;
            if (o_coef_valid) begin
                if (i_coef_ready) begin
                    beats++;
                    check("sel_upper", 32'(o_select_output_channel[7:3]), 0);
                    if (sb_q.size() == 0) check("beat_unexpected", 1, 0);
                    else check("beat", {o_coef_last, o_coef_channel, o_coef}, sb_q.pop_front());
                end else begin
                    held = {o_coef_last, o_coef_channel, o_coef};
                    hold_chk = 1'b1;
                end
            end
        end
    end

    // offer a sample until accepted; returns #1 after the accept edge
    task automatic send(input logic [7:0] s);
        int k;
        i_sample = s;
        i_sample_valid = 1'b1;
        k = 0;
        while (!o_sample_ready && k < 200) begin
            @(posedge clk); #1; k++;
        end
        check("accept_timeout", 32'(k < 200), 1);
        @(posedge clk); #1;
        i_sample_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (o_busy && k < 200) begin
            @(negedge clk); k++;
        end
        check("idle_timeout", 32'(k < 200), 1);
        check("frame_drained", sb_q.size(), 0);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_value", o_value, 0);
        check("rst_dclk", o_data_clk, 0);
        check("rst_sel", o_select_output_channel, 0);
        check("rst_coef", {o_coef_last, o_coef_channel, o_coef}, 0);
        check("rst_valid", o_coef_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_ready", o_sample_ready, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("ready_after_rst", o_sample_ready, 1);

        // single frame with defaults
        send(8'h40);
        @(negedge clk);
        check("dclk_e0", o_data_clk, 1);
        check("value_e0", o_value, 8'h40);
        @(negedge clk);
        check("dclk_e1", o_data_clk, 1);
        @(negedge clk);
        check("dclk_e2", o_data_clk, 0);
        k = 2;
        while (!o_coef_valid && k < 50) begin
            @(negedge clk); k++;
        end
        check("first_valid_latency", k, 8);
        wait_idle();
        check("beats_frame1", beats, 7);

        // backpressure on channel 3
        send(8'h50);
        k = 0;
        while (!(o_coef_valid && o_coef_channel == 3'd3) && k < 100) begin
            @(posedge clk); #1; k++;
        end
        check("ch3_timeout", 32'(k < 100), 1);
        i_coef_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("sel_held", o_select_output_channel, 3);
        end
        @(posedge clk); #1 i_coef_ready = 1'b1;
        @(posedge clk); #1;
        k = 0;
        while (!o_coef_valid && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check("beat_to_beat", k, 2);
        check("next_channel", o_coef_channel, 4);
        wait_idle();

        // sample offered during a frame waits for IDLE
        send(8'h21);
        i_sample = 8'h7F;
        i_sample_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (o_busy) begin
            if (o_value !== 8'h21 || o_sample_ready) k++;
            @(negedge clk);
        end
        check("value_held_in_frame", k, 0);
        check("ready_after_last", o_sample_ready, 1);
        @(posedge clk); #1 i_sample_valid = 1'b0;
        @(negedge clk);
        check("value_next", o_value, 8'h7F);
        check("dclk_next", o_data_clk, 1);
        wait_idle();

        // reset in WAIT_MUX at channel 2 discards the frame
        send(8'h33);
        k = 0;
        while (!(o_select_output_channel == 8'd2 && !o_coef_valid && o_busy) && k < 100) begin
            @(posedge clk); #1; k++;
        end
        check("ch2_timeout", 32'(k < 100), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", o_coef_valid, 0);
        check("mid_rst_dclk", o_data_clk, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_sel", o_select_output_channel, 0);
        sb_q.delete();
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        send(8'h44);
        wait_idle();

`ifdef WAVELET_DRIVER_MASK_EN
        mask_drv = 7'b1010010;
        k = beats;
        send(8'h60);
        wait_idle();
        check("masked_beats", beats - k, 3);
        mask_drv = '0;
        k = beats;
        send(8'h61);
        repeat (6) @(negedge clk);
        check("zero_mask_busy_e5", o_busy, 1);
        @(negedge clk);
        check("zero_mask_busy_e6", o_busy, 0);
        check("zero_mask_beats", beats - k, 0);
        mask_drv = '1;
`endif

        repeat (3) @(negedge clk);
        check("sb_empty_end", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
